ccsds_turbo_enc_rsc: RTL and testbench

- Constituent recursive systematic convolutional (RSC) encoder for the CCSDS turbo code: 16 states, K=5, feedback G0 = 1+D^3+D^4 (octal 23).
- Forward generators: G1 = 1+D+D^3+D^4 (33), G2 = 1+D^2+D^4 (25), G3 = 1+D+D^2+D^3+D^4 (37).
- Encodes one bit per enabled cycle, then appends 4 trellis-termination bits that return the state to 0.
- Two instances (natural order and interleaved order) feed the turbo encoder puncturing/mux stage. This block produces the code streams that the decoder's alpha/beta/Lapo pipeline consumes.

---
 rtl/ccsds_turbo_enc_rsc.sv | 146 ++++++++++++++
 tb/tb_ccsds_turbo_enc_rsc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccsds_turbo_enc_rsc.sv
// ----------------------------------------------------------------------------
// ccsds_turbo_enc_rsc
// Constituent recursive systematic convolutional encoder for the CCSDS turbo
// code. It has 16 states (K=5) and feedback polynomial G0 = 1+D^3+D^4.
// The forward polynomials are G1 = 1+D+D^3+D^4, G2 = 1+D^2+D^4 and
// G3 = 1+D+D^2+D^3+D^4.
// The encoder accepts one information bit per enabled cycle. When
// pUSE_TAIL is set, it then appends four trellis-termination symbols that
// return the state to zero.
//
// Ports
//   iclk, ireset     clock and asynchronous active-high reset
//   iclkena          clock enable; the whole block freezes while low
//   ival/isop/ieop   input bit valid, first and last bit of frame
//   idat             information bit u
//   ordy             encoder accepts ival this cycle (low during tail)
//   oval/osop/oeop   output symbol valid, first and last symbol of frame
//   otail            symbol is a termination symbol
//   osys             systematic bit (u, or feedback bit during tail)
//   opar             parity {G3,G2,G1}
// ----------------------------------------------------------------------------
module ccsds_turbo_enc_rsc #(
    parameter int pUSE_TAIL = 1
) (
    input  logic       iclk,
    input  logic       ireset,
    input  logic       iclkena,
    input  logic       ival,
    input  logic       isop,
    input  logic       ieop,
    input  logic       idat,
    output logic       ordy,
    output logic       oval,
    output logic       osop,
    output logic       oeop,
    output logic       otail,
    output logic       osys,
    output logic [2:0] opar
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t     fsm, fsm_nxt;
    logic [3:0] s;
    logic [1:0] tcnt, tcnt_nxt;
    logic       acc;

    logic       enc_go_p0;
    logic       enc_u_p0;
    logic [3:0] enc_s_p0;
    logic       sop_p0, eop_p0, tail_p0;
    logic [6:0] enc_r_p0;

    // One trellis step: returns {next state, G3, G2, G1}.
    // s[0] is the newest feedback bit a(k-1), and s[3] is the oldest, a(k-4).
    function automatic logic [6:0] rsc_step(input logic u, input logic [3:0] st);
        logic a;
        logic [2:0] p;
        a    = u ^ st[2] ^ st[3];
        p[0] = a ^ st[0] ^ st[2] ^ st[3];
        p[1] = a ^ st[1] ^ st[3];
        p[2] = a ^ st[0] ^ st[1] ^ st[2] ^ st[3];
        return {st[2:0], a, p};
    endfunction

    assign ordy     = (fsm != TAIL);
    assign acc      = iclkena & ival & ordy;
    assign enc_r_p0 = rsc_step(enc_u_p0, enc_s_p0);

    // Stage p0: frame control and encoder operand selection
    always_comb begin
        fsm_nxt   = fsm;
        tcnt_nxt  = tcnt;
        enc_go_p0 = 1'b0;
        enc_u_p0  = idat;
        enc_s_p0  = s;
        sop_p0    = 1'b0;
        eop_p0    = 1'b0;
        tail_p0   = 1'b0;
        case (fsm)
            IDLE, DATA: begin
                // In IDLE, a bit without isop is not part of any frame and is discarded.
                if (acc && (isop || fsm == DATA)) begin
                    enc_go_p0 = 1'b1;
                    fsm_nxt   = DATA;
                    if (isop) begin
                        // A new frame always starts from the zero state,
                        // even if it interrupts an unfinished one.
                        enc_s_p0 = 4'd0;
                        sop_p0   = 1'b1;
                    end
                    if (ieop) begin
                        if (pUSE_TAIL != 0) begin
                            fsm_nxt = TAIL;
                        end else begin
                            fsm_nxt = IDLE;
                            eop_p0  = 1'b1;
                        end
                    end
                end
            end
            TAIL: begin
                // Choosing u equal to the feedback bit forces a=0.
                // After four such steps the register is flushed to zero.
                enc_go_p0 = 1'b1;
                enc_u_p0  = s[2] ^ s[3];
                tail_p0   = 1'b1;
                tcnt_nxt  = tcnt + 2'd1;
                if (tcnt == 2'd3) begin
                    eop_p0   = 1'b1;
                    fsm_nxt  = IDLE;
                    tcnt_nxt = 2'd0;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Stage p1: registered state and output symbol
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            fsm   <= IDLE;
            tcnt  <= 2'd0;
            s     <= 4'd0;
            oval  <= 1'b0;
            osop  <= 1'b0;
            oeop  <= 1'b0;
            otail <= 1'b0;
            osys  <= 1'b0;
            opar  <= 3'd0;
        end else if (iclkena) begin
            fsm   <= fsm_nxt;
            tcnt  <= tcnt_nxt;
            oval  <= enc_go_p0;
            osop  <= sop_p0;
            oeop  <= eop_p0;
            otail <= tail_p0;
            if (enc_go_p0) begin
                s    <= enc_r_p0[6:3];
                osys <= enc_u_p0;
                opar <= enc_r_p0[2:0];
            end
        end
    end

endmodule

// File: tb/tb_ccsds_turbo_enc_rsc.sv
// ----------------------------------------------------------------------------
// tb_ccsds_turbo_enc_rsc
// Directed bench for the CCSDS RSC constituent encoder. One instance uses
// termination; a second instance runs with pUSE_TAIL=0. The first frames
// are checked against hand-computed symbols. The longer frames are checked
// against a polynomial-mask reference model.
// Symbols are packed as {osop,oeop,otail,osys,opar[2:0]}.
// ----------------------------------------------------------------------------
module tb_ccsds_turbo_enc_rsc;

    logic       iclk = 1'b0;
    logic       ireset = 1'b1;
    logic       iclkena = 1'b1;
    logic       ival = 1'b0, isop = 1'b0, ieop = 1'b0, idat = 1'b0;
    logic       ordy, oval, osop, oeop, otail, osys;
    logic [2:0] opar;

    logic       ival0 = 1'b0, isop0 = 1'b0, ieop0 = 1'b0, idat0 = 1'b0;
    logic       ordy_0, oval_0, osop_0, oeop_0, otail_0, osys_0;
    logic [2:0] opar_0;

    always #5 iclk = ~iclk;

    ccsds_turbo_enc_rsc #(.pUSE_TAIL(1)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ival(ival), .isop(isop), .ieop(ieop), .idat(idat),
        .ordy(ordy), .oval(oval), .osop(osop), .oeop(oeop),
        .otail(otail), .osys(osys), .opar(opar)
    );

    ccsds_turbo_enc_rsc #(.pUSE_TAIL(0)) dut0 (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .ival(ival0), .isop(isop0), .ieop(ieop0), .idat(idat0),
        .ordy(ordy_0), .oval(oval_0), .osop(osop_0), .oeop(oeop_0),
        .otail(otail_0), .osys(osys_0), .opar(opar_0)
    );

    // Polynomial masks, with bit i being the coefficient of D^i
    localparam logic [4:0] G0M = 5'b11001;
    localparam logic [4:0] G1M = 5'b11011;
    localparam logic [4:0] G2M = 5'b10101;
    localparam logic [4:0] G3M = 5'b11111;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] got_q[$], exp_q[$], got0_q[$], exp0_q[$];
    int         cyc_q[$];
    int         cyc = 0;
    int         low_cnt = 0;
    int         tail0_cnt = 0;
    bit         en_rand = 1'b0;
    logic       en_q;
    logic       fbits[2048];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output capture: count only the edges that were actually enabled
    always @(posedge iclk) begin
        en_q = iclkena;
        if (en_q && !ordy) low_cnt++;
        #1;
        if (en_q) cyc++;
        if (en_q && oval && !ireset) begin
            got_q.push_back({osop, oeop, otail, osys, opar});
            cyc_q.push_back(cyc);
        end
        if (en_q && oval_0 && !ireset) begin
            got0_q.push_back({osop_0, oeop_0, otail_0, osys_0, opar_0});
            if (otail_0) tail0_cnt++;
        end
    end

    // Reference model: feedback register m holds a(k-i) in bit i (bit 0 unused)
    task automatic model_frame(input int len, input int off, input bit term,
                               input bit use_tail, input bit to0);
        logic [4:0] m, v;
        logic       u, a, eop;
        logic [2:0] p;
        logic [6:0] sym;
        m = 5'd0;
        for (int k = 0; k < len; k++) begin
            u   = fbits[off + k];
            a   = u ^ (^(m & G0M));
            v   = {m[4:1], a};
            p   = {^(v & G3M), ^(v & G2M), ^(v & G1M)};
            eop = term && !use_tail && (k == len - 1);
            sym = {(k == 0), eop, 1'b0, u, p};
            if (to0) exp0_q.push_back(sym); else exp_q.push_back(sym);
            m = {v[3:0], 1'b0};
        end
        if (term && use_tail) begin
            for (int t = 0; t < 4; t++) begin
                u   = ^(m & G0M);
                v   = m;
                p   = {^(v & G3M), ^(v & G2M), ^(v & G1M)};
                sym = {1'b0, (t == 3), 1'b1, u, p};
                exp_q.push_back(sym);
                m = {v[3:0], 1'b0};
            end
        end
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_sym%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        cyc_q.delete();
    endtask

    task automatic step();
        @(negedge iclk);
        iclkena = en_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            ival = 1'b0; isop = 1'b0; ieop = 1'b0;
            ival0 = 1'b0; isop0 = 1'b0; ieop0 = 1'b0;
        end
    endtask

    // Present one bit and hold it until the selected encoder accepts it
    task automatic send_bit(input bit sel, input logic u, input logic sop, input logic eop);
        int tries;
        bit done;
        tries = 0;
        done  = 1'b0;
        while (!done) begin
            step();
            if (sel) begin
                ival0 = 1'b1; idat0 = u; isop0 = sop; ieop0 = eop;
            end else begin
                ival = 1'b1; idat = u; isop = sop; ieop = eop;
            end
            #1;
            done = iclkena && (sel ? ordy_0 : ordy);
            tries++;
            if (!done && tries > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_wait: got no ordy in %0d cycles, expected acceptance", tries);
                done = 1'b1;
            end
        end
    endtask

    // First frame: 1024 bits terminated with a tail. A second 8-bit frame
    // is queued behind it, so its first bit waits out the tail.
    task automatic run_long(input string tag);
        for (int k = 0; k < 1024; k++) send_bit(1'b0, fbits[k], k == 0, k == 1023);
        for (int k = 0; k < 8; k++) send_bit(1'b0, fbits[1024 + k], k == 0, k == 7);
        idle(80);
        model_frame(1024, 0, 1'b1, 1'b1, 1'b0);
        model_frame(8, 1024, 1'b1, 1'b1, 1'b0);
        if (got_q.size() > 1028) begin
            chk({tag, "_b2b_gap"}, cyc_q[1028] - cyc_q[1027], 1);
            chk({tag, "_b2b_eop_sop"}, int'({got_q[1027][5], got_q[1028][6]}), 3);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_b2b: got %0d symbols, expected at least 1029", tag, got_q.size());
        end
        cmp_q(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_ordy", ordy, 1);
        chk("rst_outs", int'({oval, osop, oeop, otail, osys, opar}), 0);
        @(negedge iclk);
        ireset = 1'b0;
        low_cnt = 0;

        // A two-bit unterminated frame is followed by a single-bit frame
        // that ends with a tail. Expected symbols are hand-computed.
        send_bit(1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b1, 1'b1);
        idle(12);
        exp_q.push_back(7'b1001111);
        exp_q.push_back(7'b0000101);
        exp_q.push_back(7'b1001111);
        exp_q.push_back(7'b0010101);
        exp_q.push_back(7'b0010110);
        exp_q.push_back(7'b0011101);
        exp_q.push_back(7'b0111111);
        cmp_q("hand");
        chk("hand_ordy_low", low_cnt, 4);

        // Long random frame, then the same frame with a random clock enable
        for (int i = 0; i < 1032; i++) fbits[i] = 1'($urandom_range(0, 1));
        run_long("long");
        en_rand = 1'b1;
        run_long("long_ena");
        en_rand = 1'b0;

        // isop arrives mid-frame: the 5-bit frame is cut off with no tail
        for (int i = 0; i < 8; i++) fbits[i] = 1'($urandom_range(0, 1));
        fbits[5] = 1'b1;
        for (int k = 0; k < 5; k++) send_bit(1'b0, fbits[k], k == 0, 1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'b0, fbits[5 + k], k == 0, k == 2);
        idle(12);
        model_frame(5, 0, 1'b0, 1'b1, 1'b0);
        model_frame(3, 5, 1'b1, 1'b1, 1'b0);
        cmp_q("restart");
        for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("idle_drop", got_q.size(), 0);
        got_q.delete();

        // Reset during the second tail cycle
        send_bit(1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        idle(1);
        #1 ireset = 1'b1;
        #1;
        chk("midtail_rst_outs", int'({oval, osop, oeop, otail, osys, opar}), 0);
        chk("midtail_rst_ordy", ordy, 1);
        step();
        ireset = 1'b0;
        @(posedge iclk);
        #2;
        chk("post_rst_ordy", ordy, 1);
        chk("post_rst_oval", oval, 0);
        got_q.delete();
        exp_q.delete();
        cyc_q.delete();
        for (int i = 0; i < 6; i++) fbits[i] = 1'($urandom_range(0, 1));
        for (int k = 0; k < 6; k++) send_bit(1'b0, fbits[k], k == 0, k == 5);
        idle(12);
        model_frame(6, 0, 1'b1, 1'b1, 1'b0);
        cmp_q("post_rst");

        // Instance without termination: eop falls on the last data symbol
        for (int i = 0; i < 10; i++) fbits[i] = 1'($urandom_range(0, 1));
        fbits[0] = 1'b1;
        for (int k = 0; k < 6; k++) send_bit(1'b1, fbits[k], k == 0, k == 5);
        for (int k = 0; k < 4; k++) send_bit(1'b1, fbits[6 + k], k == 0, k == 3);
        idle(8);
        model_frame(6, 0, 1'b1, 1'b0, 1'b1);
        model_frame(4, 6, 1'b1, 1'b0, 1'b1);
        chk("notail_count", got0_q.size(), exp0_q.size());
        for (int i = 0; i < exp0_q.size() && i < got0_q.size(); i++)
            chk($sformatf("notail_sym%0d", i), int'(got0_q[i]), int'(exp0_q[i]));
        chk("notail_otail", tail0_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
